// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-outstanding imem requests and
// fills the IF/ID register, with a one-entry skid buffer for responses caught by a stall.
module inst_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instruction,
    output logic [63:0] if_id_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] req_pc;
    logic        pend_valid;
    logic [31:0] pend_instr;
    logic [63:0] pend_pc;
    logic        accept;

    // A response only counts if it answers a live request and no redirect kills it.
    assign accept    = (state == S_WAIT) && imem_rvalid && !redirect;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        imem_req   = 1'b0;
        state_next = state;
        if (!reset && !redirect && !pend_valid) begin
            imem_req = (state == S_IDLE) ||
                       ((state == S_WAIT) && imem_rvalid && !stall);
        end
        unique case (state)
            S_IDLE: begin
                if (imem_req) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? S_IDLE : S_DISCARD;
                end else if (imem_rvalid) begin
                    state_next = imem_req ? S_WAIT : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (imem_req) begin
            req_pc <= pc;
            pc     <= pc + 64'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_instr <= NOP_INSTR;
            pend_pc    <= 64'h0;
        end else if (redirect) begin
            pend_valid <= 1'b0;
        end else if (!stall) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            // Requests are blocked while pend is full, so this never overwrites a live entry.
            pend_valid <= 1'b1;
            pend_instr <= imem_rdata;
            pend_pc    <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= 64'h0;
        end else if (redirect) begin
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
        end else if (!stall) begin
            if (pend_valid) begin
                if_id_valid       <= 1'b1;
                if_id_instruction <= pend_instr;
                if_id_pc          <= pend_pc;
            end else if (accept) begin
                if_id_valid       <= 1'b1;
                if_id_instruction <= imem_rdata;
                if_id_pc          <= req_pc;
            end else begin
                if_id_valid       <= 1'b0;
                if_id_instruction <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic against a transaction-level model of the fetch stage.
module tb_inst_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instruction;
    logic [63:0] if_id_pc;

    always #5 clk = ~clk;

    inst_fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .if_id_valid      (if_id_valid),
        .if_id_instruction(if_id_instruction),
        .if_id_pc         (if_id_pc)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    // Model: a fetch is either absent, live, or poisoned by a redirect; the
    // skid buffer is a queue; IF/ID is a plain record.
    logic [63:0] m_pc = RST_PC;
    bit          m_out = 0;
    bit          m_pois = 0;
    logic [63:0] m_req_pc = RST_PC;
    entry_t      pend_q[$];
    bit          m_valid = 0;
    logic [31:0] m_instr = NOP;
    logic [63:0] m_ipc = 64'h0;

    // Memory: a single response slot with a countdown.
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    logic [63:0] mem_addr = 64'h0;
    int          lat_fix = 1;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit rd, input logic [63:0] rpc,
                        input bit frv, input logic [31:0] fdata);
        logic        rv;
        logic [31:0] rdat;
        bit          e_req;
        bit          good;
        entry_t      e;
        @(negedge clk);
        rv   = 1'b0;
        rdat = $urandom();
        if (mem_busy && mem_cnt == 0) begin
            rv       = 1'b1;
            rdat     = mem_word(mem_addr);
            mem_busy = 0;
        end
        if (frv) begin
            rv   = 1'b1;
            rdat = fdata;
        end
        reset       = rst;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        #1;
        e_req = !rst && !rd && (pend_q.size() == 0) && (!m_out || (!m_pois && rv && !st));
        check("imem_req", 64'(imem_req), 64'(e_req));
        check("imem_addr", imem_addr, m_pc);
        check("if_id_valid", 64'(if_id_valid), 64'(m_valid));
        check("if_id_instruction", 64'(if_id_instruction), 64'(m_instr));
        check("if_id_pc", if_id_pc, m_ipc);
        if (rst) begin
            m_pc = RST_PC;
            m_out = 0;
            m_pois = 0;
            pend_q.delete();
            m_valid = 0;
            m_instr = NOP;
            m_ipc = 64'h0;
            mem_busy = 0;
        end else begin
            good = m_out && !m_pois && rv && !rd;
            if (rd) begin
                m_pc = rpc;
                pend_q.delete();
                m_valid = 0;
                m_instr = NOP;
            end else if (!st) begin
                if (pend_q.size() != 0) begin
                    e = pend_q.pop_front();
                    m_valid = 1;
                    m_instr = e.instr;
                    m_ipc = e.pc;
                end else if (good) begin
                    m_valid = 1;
                    m_instr = rdat;
                    m_ipc = m_req_pc;
                end else begin
                    m_valid = 0;
                    m_instr = NOP;
                end
            end else if (good) begin
                pend_q.push_back('{instr: rdat, pc: m_req_pc});
            end
            if (m_out && rv) begin
                m_out = 0;
                m_pois = 0;
            end else if (m_out && rd) begin
                m_pois = 1;
            end
            if (e_req) begin
                m_out = 1;
                m_pois = 0;
                m_req_pc = m_pc;
                m_pc = m_pc + 64'd4;
            end
            if (mem_busy) mem_cnt--;
            if (imem_req) begin
                mem_busy = 1;
                mem_addr = imem_addr;
                mem_cnt  = ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3))) - 1;
            end
        end
    endtask

    initial begin
        bit          r, s, d, f;
        logic [63:0] t;

        step(1, 0, 0, 64'h0, 0, 32'h0);
        step(1, 0, 0, 64'h0, 0, 32'h0);
        check("reset if_id_instruction", 64'(if_id_instruction), 64'h13);
        check("reset if_id_pc", if_id_pc, 64'h0);

        // Back-to-back fetch with 1-cycle memory.
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("first req", 64'(imem_req), 64'h1);
        check("first addr", imem_addr, 64'h1000);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("second addr", imem_addr, 64'h1004);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("third addr", imem_addr, 64'h1008);
        check("ifid pc 1000", if_id_pc, 64'h1000);
        check("ifid valid", 64'(if_id_valid), 64'h1);

        // Stall for 3 cycles while 0x00500093 arrives.
        step(0, 1, 0, 64'h0, 1, 32'h0050_0093);
        check("stall no req", 64'(imem_req), 64'h0);
        step(0, 1, 0, 64'h0, 0, 32'h0);
        check("pend full", 64'(dut.pend_valid), 64'h1);
        check("pend blocks req", 64'(imem_req), 64'h0);
        check("stall hold pc", if_id_pc, 64'h1004);
        step(0, 1, 0, 64'h0, 0, 32'h0);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        lat_fix = 2;
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("pend instr out", 64'(if_id_instruction), 64'h0050_0093);
        check("pend pc out", if_id_pc, 64'h1008);
        check("resume addr", imem_addr, 64'h100C);
        check("resume req", 64'(imem_req), 64'h1);

        // Redirect in WAIT, response one cycle later is discarded.
        step(0, 0, 1, 64'h2000, 0, 32'h0);
        check("redirect no req", 64'(imem_req), 64'h0);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("discard invalid", 64'(if_id_valid), 64'h0);
        check("discard no req", 64'(imem_req), 64'h0);
        lat_fix = 1;
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("req 2000", imem_addr, 64'h2000);

        // Redirect coincident with rvalid.
        step(0, 0, 1, 64'h3000, 0, 32'h0);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("req 3000", imem_addr, 64'h3000);
        check("req 3000 valid", 64'(imem_req), 64'h1);

        // Redirect under stall with pend full.
        step(0, 1, 0, 64'h0, 0, 32'h0);
        step(0, 1, 1, 64'h4000, 0, 32'h0);
        check("pend before redirect", 64'(dut.pend_valid), 64'h1);
        step(0, 1, 0, 64'h0, 0, 32'h0);
        check("pend cleared", 64'(dut.pend_valid), 64'h0);
        check("redirect stall valid", 64'(if_id_valid), 64'h0);
        check("redirect stall nop", 64'(if_id_instruction), 64'h13);

        // Reset in WAIT, then a late response.
        step(1, 0, 0, 64'h0, 0, 32'h0);
        check("reset no req", 64'(imem_req), 64'h0);
        step(0, 0, 0, 64'h0, 1, 32'hDEAD_BEEF);
        check("post reset addr", imem_addr, 64'h1000);
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0);
        check("late resp ignored", 64'(if_id_valid), 64'h0);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("top addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 64'h0, 0, 32'h0);
        check("wrapped addr", imem_addr, 64'h0);

        // Randomized traffic.
        lat_fix = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                             : ({$urandom(), $urandom()} & ~64'h3);
            f = !mem_busy && ($urandom_range(0, 19) == 0);
            step(r, s, d, t, f, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
